// File: rtl/dmem_pkg.sv
// dmem_pkg: size/error encodings, FSM states and request checker shared by the data-memory access unit.
package dmem_pkg;
  typedef enum logic [1:0] {
    SZ_NONE = 2'b00,
    SZ_WORD = 2'b01,
    SZ_HALF = 2'b10,
    SZ_BYTE = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_ALIGN = 2'b01,
    ERR_RANGE = 2'b10,
    ERR_SIZE  = 2'b11
  } err_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_e;

  // Offset is computed modulo 2^32 so addresses below base wrap high and fail the range test.
  function automatic logic [1:0] check_req(input logic [1:0] size, input logic [31:0] addr,
                                           input logic [31:0] base, input logic [31:0] bytes);
    logic [31:0] off;
    off = addr - base;
    return size == SZ_NONE ? ERR_SIZE :
           off >= bytes ? ERR_RANGE :
           ((size == SZ_WORD && addr[1:0] != 2'b00) || (size == SZ_HALF && addr[0])) ? ERR_ALIGN :
           ERR_NONE;
  endfunction
endpackage

// File: rtl/dmem_access_unit_load_extend.sv
// load_extend: sign/zero extends a low-aligned memory read lane to 32 bits.
module load_extend
  import dmem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] data
);
  always_comb begin
    data = size == SZ_BYTE ? {{24{is_signed & rdata[7]}}, rdata[7:0]} :
           size == SZ_HALF ? {{16{is_signed & rdata[15]}}, rdata[15:0]} :
           rdata;
  end
endmodule

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: MEM-stage initiator issuing one checked load/store per request, with registered
// outputs and a valid/ready response carrying extended load data and an error code.
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  resp_err_code,
  output logic        mem_ena,
  output logic        mem_wena,
  output logic [1:0]  mem_wsel,
  output logic [1:0]  mem_rsel,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  state_e      state, state_nx;
  logic        l_we, l_signed;
  logic [1:0]  l_size;
  logic        accept;
  logic [1:0]  err_in;
  logic [31:0] ext_data;
  logic        req_ready_nx, resp_valid_nx, resp_err_nx, mem_ena_nx, mem_wena_nx;
  logic [1:0]  resp_err_code_nx, mem_wsel_nx, mem_rsel_nx;
  logic [31:0] resp_rdata_nx, mem_addr_nx, mem_wdata_nx;

  assign accept = req_valid && req_ready;
  assign err_in = check_req(req_size, req_addr, BASE_ADDR, 32'(MEM_BYTES));

  load_extend u_ext (
    .rdata    (mem_rdata),
    .size     (l_size),
    .is_signed(l_signed),
    .data     (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end

  always_comb begin
    state_nx = (state == IDLE && accept) ? (err_in != ERR_NONE ? RESP : ACCESS) :
               state == ACCESS ? RESP :
               (state == RESP && resp_ready) ? IDLE :
               state;
  end

  // Next values of the registered outputs; memory fields are only loaded on the IDLE->ACCESS edge.
  always_comb begin
    req_ready_nx     = state_nx == IDLE;
    resp_valid_nx    = state_nx == RESP;
    mem_ena_nx       = state_nx == ACCESS;
    mem_wena_nx      = mem_ena_nx && req_we;
    mem_wsel_nx      = mem_wena_nx ? req_size : SZ_NONE;
    mem_rsel_nx      = (mem_ena_nx && !req_we) ? req_size : SZ_NONE;
    mem_addr_nx      = mem_ena_nx ? req_addr : '0;
    mem_wdata_nx     = mem_wena_nx ? req_wdata : '0;
    resp_rdata_nx    = state == ACCESS ? (l_we ? '0 : ext_data) : accept ? '0 : resp_rdata;
    resp_err_nx      = state == ACCESS ? 1'b0 : accept ? (err_in != ERR_NONE) : resp_err;
    resp_err_code_nx = state == ACCESS ? ERR_NONE : accept ? err_in : resp_err_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_err      <= 1'b0;
      resp_err_code <= ERR_NONE;
      mem_ena       <= 1'b0;
      mem_wena      <= 1'b0;
      mem_wsel      <= SZ_NONE;
      mem_rsel      <= SZ_NONE;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      l_we          <= 1'b0;
      l_size        <= SZ_NONE;
      l_signed      <= 1'b0;
    end else begin
      req_ready     <= req_ready_nx;
      resp_valid    <= resp_valid_nx;
      resp_rdata    <= resp_rdata_nx;
      resp_err      <= resp_err_nx;
      resp_err_code <= resp_err_code_nx;
      mem_ena       <= mem_ena_nx;
      mem_wena      <= mem_wena_nx;
      mem_wsel      <= mem_wsel_nx;
      mem_rsel      <= mem_rsel_nx;
      mem_addr      <= mem_addr_nx;
      mem_wdata     <= mem_wdata_nx;
      if (accept) begin
        l_we     <= req_we;
        l_size   <= req_size;
        l_signed <= req_signed;
      end
    end
  end
endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: directed stimulus with a response scoreboard and a byte-array memory model.
module tb_dmem_access_unit;
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  code;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0, resp_ready = 1'b1;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, mem_ena, mem_wena;
  logic [1:0]  resp_err_code, mem_wsel, mem_rsel;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

  logic [7:0]  mem [4096];
  logic [11:0] mo;
  exp_t        q[$];
  exp_t        e;
  int          compared = 0, mismatched = 0, ena_cnt = 0;

  always #5 clk = ~clk;

  dmem_access_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .resp_err_code(resp_err_code),
    .mem_ena(mem_ena), .mem_wena(mem_wena), .mem_wsel(mem_wsel), .mem_rsel(mem_rsel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mo = mem_addr[11:0];

  always_comb begin
    mem_rdata = '0;
    if (mem_ena && !mem_wena)
      mem_rdata = mem_rsel == 2'b01 ? {mem[12'(mo + 3)], mem[12'(mo + 2)], mem[12'(mo + 1)], mem[mo]} :
                  mem_rsel == 2'b10 ? {16'h0, mem[12'(mo + 1)], mem[mo]} :
                  mem_rsel == 2'b11 ? {24'h0, mem[mo]} : 32'h0;
  end

  always @(posedge clk) begin
    if (mem_ena && mem_wena) begin
      mem[mo] = mem_wdata[7:0];
      if (mem_wsel != 2'b11) mem[12'(mo + 1)] = mem_wdata[15:8];
      if (mem_wsel == 2'b01) begin
        mem[12'(mo + 2)] = mem_wdata[23:16];
        mem[12'(mo + 3)] = mem_wdata[31:24];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_ena) ena_cnt++;
    if (rst_n && resp_valid && resp_ready) begin
      if (q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_resp: got rdata %h err %b code %b expected no response",
                 resp_rdata, resp_err, resp_err_code);
      end else begin
        e = q.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", 32'(resp_err), 32'(e.err));
        chk("resp_err_code", 32'(resp_err_code), 32'(e.code));
      end
    end
  end

  task automatic send(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] er, input logic ee, input logic [1:0] ec);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("req_ready_before_send", 32'(req_ready), 32'd1);
    q.push_back({er, ee, ec});
    req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(req_ready && !resp_valid) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("return_to_idle", 32'(req_ready && !resp_valid), 32'd1);
  endtask

  initial begin
    int e0, n;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[2] = 8'h01;
    mem[3] = 8'h80;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {resp_err, resp_err_code}, 32'd0);
    chk("rst_mem", {mem_ena, mem_wena, mem_wsel, mem_rsel}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    send(1'b1, 2'b01, 1'b0, 32'h1001_0004, 32'hDEAD_BEEF, 32'h0, 1'b0, 2'b00);
    chk("st_mem_ctl", {mem_ena, mem_wena, mem_wsel, mem_rsel}, 32'b1_1_01_00);
    chk("st_mem_addr", mem_addr, 32'h1001_0004);
    chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("st_resp_valid_t1", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    chk("st_resp_valid_t2", 32'(resp_valid), 32'd1);
    chk("st_mem_ena_after", 32'(mem_ena), 32'd0);
    wait_idle();

    send(1'b0, 2'b01, 1'b0, 32'h1001_0004, 32'h0, 32'hDEAD_BEEF, 1'b0, 2'b00);
    chk("ld_mem_ctl", {mem_ena, mem_wena, mem_wsel, mem_rsel}, 32'b1_0_00_01);
    wait_idle();
    send(1'b0, 2'b11, 1'b1, 32'h1001_0003, 32'h0, 32'hFFFF_FF80, 1'b0, 2'b00);
    wait_idle();
    send(1'b0, 2'b11, 1'b0, 32'h1001_0003, 32'h0, 32'h0000_0080, 1'b0, 2'b00);
    wait_idle();
    send(1'b0, 2'b10, 1'b1, 32'h1001_0002, 32'h0, 32'hFFFF_8001, 1'b0, 2'b00);
    wait_idle();
    send(1'b0, 2'b10, 1'b0, 32'h1001_0002, 32'h0, 32'h0000_8001, 1'b0, 2'b00);
    wait_idle();

    e0 = ena_cnt;
    send(1'b0, 2'b01, 1'b0, 32'h1001_0002, 32'h0, 32'h0, 1'b1, 2'b01);
    wait_idle();
    send(1'b0, 2'b01, 1'b0, 32'h1001_1000, 32'h0, 32'h0, 1'b1, 2'b10);
    wait_idle();
    send(1'b0, 2'b01, 1'b0, 32'h1000_FFFC, 32'h0, 32'h0, 1'b1, 2'b10);
    wait_idle();
    send(1'b0, 2'b00, 1'b0, 32'h1001_0000, 32'h0, 32'h0, 1'b1, 2'b11);
    wait_idle();
    send(1'b1, 2'b10, 1'b0, 32'h1001_0003, 32'h1234, 32'h0, 1'b1, 2'b01);
    wait_idle();
    chk("err_no_mem_ena", 32'(ena_cnt - e0), 32'd0);

    resp_ready = 1'b0;
    send(1'b0, 2'b01, 1'b0, 32'h1001_0004, 32'h0, 32'hDEAD_BEEF, 1'b0, 2'b00);
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    e0 = ena_cnt;
    for (int i = 0; i < 5; i++) begin
      req_we = 1'b1; req_size = 2'b01; req_addr = 32'h1001_0000; req_wdata = 32'h5555_AAAA;
      req_valid = (i == 1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("bp_resp_valid", 32'(resp_valid), 32'd1);
      chk("bp_resp_rdata", resp_rdata, 32'hDEAD_BEEF);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    chk("bp_no_mem_ena", 32'(ena_cnt - e0), 32'd0);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_idle", {req_ready, resp_valid}, 32'b10);

    req_we = 1'b1; req_size = 2'b01; req_signed = 1'b0; req_addr = 32'h1001_0010;
    req_wdata = 32'h1234_5678; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_acc_mem_before", {mem_ena, mem_wena}, 32'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_acc_mem_ctl", {mem_ena, mem_wena, mem_wsel, mem_rsel}, 32'd0);
    chk("rst_acc_mem_addr", mem_addr, 32'd0);
    chk("rst_acc_hs", {req_ready, resp_valid}, 32'b10);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    send(1'b0, 2'b11, 1'b0, 32'h1001_0003, 32'h0, 32'h0000_0080, 1'b0, 2'b00);
    wait_idle();
    chk("scoreboard_drained", q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
